// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants, digit type and FSM states for the time feeder
package clock_pkg;

    localparam int FRAME_DIGITS = 6;
    localparam int DOT_BIT      = 4;

    // Send order; the last digit sent lands at display position 0
    localparam int ORD_H_T = 0;
    localparam int ORD_H_U = 1;
    localparam int ORD_M_T = 2;
    localparam int ORD_M_U = 3;
    localparam int ORD_S_T = 4;
    localparam int ORD_S_U = 5;

    typedef logic [DOT_BIT:0] digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } fsm_state_t;

    function automatic digit_t mk_digit(input logic [3:0] bcd, input logic dot);
        return {dot, bcd};
    endfunction

endpackage

// File: rtl/time_feeder_if.sv
// rtl/time_feeder_if.sv - set pulses, tick and digit/latch load bus of the time feeder
interface time_feeder_if import clock_pkg::*; ();

    logic   inc_hour;
    logic   inc_min;
    digit_t digit;
    logic   latch;
    logic   busy;
    logic   tick;

    modport master (
        input  inc_hour, inc_min,
        output digit, latch, busy, tick
    );

    modport slave (
        output inc_hour, inc_min,
        input  digit, latch, busy, tick
    );

endinterface

// File: rtl/bcd_wrap_counter.sv
// rtl/bcd_wrap_counter.sv - two-decade BCD counter wrapping from MAX to 00
module bcd_wrap_counter #(
    parameter int MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic       wrap,
    output logic [7:0] value
);

    localparam logic [3:0] MAX_T = 4'(MAX / 10);
    localparam logic [3:0] MAX_U = 4'(MAX % 10);

    logic [3:0] tens;
    logic [3:0] units;
    logic       at_max;

    assign at_max = (tens == MAX_T) && (units == MAX_U);
    assign wrap   = inc && at_max;
    assign value  = {tens, units};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens  <= '0;
            units <= '0;
        end else if (inc) begin
            if (at_max) begin
                tens  <= '0;
                units <= '0;
            end else if (units == 4'd9) begin
                tens  <= tens + 4'd1;
                units <= '0;
            end else begin
                units <= units + 4'd1;
            end
        end
    end

endmodule

// File: rtl/time_feeder.sv
// rtl/time_feeder.sv - HH:MM:SS clock serialising six-digit snapshots onto a digit/latch bus
module time_feeder import clock_pkg::*; #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic          clk,
    input  logic          rst,
    time_feeder_if.master bus
);

    localparam int             PW       = $clog2(CLK_HZ);
    localparam logic [PW-1:0]  PRE_LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] pre_cnt;
    logic          tick_now;
    logic          tick_pend;
    logic          manual;
    logic          sec_adv;
    logic          sec_wrap;
    logic          min_wrap;
    logic          req;
    logic [7:0]    hrs;
    logic [7:0]    mins;
    logic [7:0]    secs;
    logic          colon;

    fsm_state_t    state;
    fsm_state_t    state_n;
    logic          load;
    logic          last;
    logic [2:0]    idx;
    digit_t        frame [FRAME_DIGITS];

    assign tick_now = (pre_cnt == PRE_LAST);
    assign bus.tick = tick_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           pre_cnt <= '0;
        else if (tick_now) pre_cnt <= '0;
        else               pre_cnt <= pre_cnt + 1'b1;
    end

    // A manual set wins the cycle; a coincident tick is deferred by one cycle
    assign manual  = bus.inc_hour | bus.inc_min;
    assign sec_adv = !manual && (tick_now || tick_pend);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         tick_pend <= 1'b0;
        else if (manual) tick_pend <= tick_pend | tick_now;
        else             tick_pend <= 1'b0;
    end

    bcd_wrap_counter #(.MAX(59)) u_sec (
        .clk(clk), .rst(rst), .inc(sec_adv), .wrap(sec_wrap), .value(secs)
    );

    bcd_wrap_counter #(.MAX(59)) u_min (
        .clk(clk), .rst(rst), .inc(bus.inc_min | sec_wrap), .wrap(min_wrap), .value(mins)
    );

    // Hours only carry from a seconds rollover, never from a manual minute wrap
    bcd_wrap_counter #(.MAX(23)) u_hour (
        .clk(clk), .rst(rst), .inc(bus.inc_hour | (sec_wrap & min_wrap)), .wrap(), .value(hrs)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     req <= 1'b1;
        else if (manual || sec_adv)  req <= 1'b1;
        else if (load)               req <= 1'b0;
    end

    assign colon = ~secs[0];
    assign last  = (idx == 3'(FRAME_DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            for (int i = 0; i < FRAME_DIGITS; i++) frame[i] <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                idx            <= '0;
                frame[ORD_H_T] <= mk_digit(hrs[7:4],  1'b0);
                frame[ORD_H_U] <= mk_digit(hrs[3:0],  colon);
                frame[ORD_M_T] <= mk_digit(mins[7:4], 1'b0);
                frame[ORD_M_U] <= mk_digit(mins[3:0], colon);
                frame[ORD_S_T] <= mk_digit(secs[7:4], 1'b0);
                frame[ORD_S_U] <= mk_digit(secs[3:0], 1'b0);
            end else if (state == HOLD && !last) begin
                idx <= idx + 3'd1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        bus.latch = 1'b0;
        bus.busy  = (state != IDLE);
        bus.digit = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    load    = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                bus.digit = frame[idx];
                state_n   = STROBE;
            end
            STROBE: begin
                bus.digit = frame[idx];
                bus.latch = 1'b1;
                state_n   = HOLD;
            end
            HOLD: begin
                bus.digit = frame[idx];
                state_n   = last ? IDLE : SETUP;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_time_feeder.sv
// tb/tb_time_feeder.sv - randomized self-checking bench for time_feeder against a seconds-of-day model
module tb_time_feeder;
    import clock_pkg::*;

    localparam int HZ = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    time_feeder_if bus ();

    time_feeder #(.CLK_HZ(HZ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: time of day as plain integers, updated from the rules
    int m_h, m_m, m_s, m_pc, cyc;
    bit m_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_h = 0; m_m = 0; m_s = 0; m_pc = 0; m_pend = 0; cyc = 0;
        end else begin
            bit tk;
            int t;
            cyc++;
            tk   = (m_pc == HZ - 1);
            m_pc = (m_pc + 1) % HZ;
            if (bus.inc_hour || bus.inc_min) begin
                if (bus.inc_hour) m_h = (m_h + 1) % 24;
                if (bus.inc_min)  m_m = (m_m + 1) % 60;
                if (tk) m_pend = 1;
            end else if (tk || m_pend) begin
                t   = ((m_h * 60 + m_m) * 60 + m_s + 1) % 86400;
                m_h = t / 3600;
                m_m = (t / 60) % 60;
                m_s = t % 60;
                m_pend = 0;
            end
        end
    end

    function automatic logic [29:0] exp_frame(input int h, input int m, input int s);
        logic c;
        c = ((s % 10) % 2) == 0;
        return {5'(h / 10), c, 4'(h % 10), 5'(m / 10), c, 4'(m % 10), 5'(s / 10), 5'(s % 10)};
    endfunction

    // Bus monitor: assembles frames from latch falling edges, checks digit stability and tick
    logic [29:0] frames [$];
    logic [29:0] cur, last_frame;
    logic [4:0]  prev_digit, latch_digit;
    logic        prev_latch;
    int nfall, fs_cur, fs_last, fs_prev, done_cyc, stab_err, tick_err, tick_count;

    initial begin
        stab_err = 0; tick_err = 0; last_frame = '0; fs_last = 0; fs_prev = 0; done_cyc = 0;
    end

    always @(negedge clk) begin
        if (rst) begin
            nfall = 0; cur = '0; prev_latch = 0; prev_digit = '0; tick_count = 0;
        end else begin
            if (bus.tick !== (m_pc == HZ - 1)) tick_err++;
            if (bus.tick) tick_count++;
            if (!prev_latch && bus.latch) begin
                if (bus.digit !== prev_digit) stab_err++;
                latch_digit = bus.digit;
                if (nfall % 6 == 0) fs_cur = cyc;
            end
            if (prev_latch && !bus.latch) begin
                if (bus.digit !== latch_digit) stab_err++;
                cur = {cur[24:0], bus.digit};
                nfall++;
                if (nfall % 6 == 0) begin
                    frames.push_back(cur);
                    last_frame = cur;
                    fs_prev = fs_last;
                    fs_last = fs_cur;
                    done_cyc = cyc;
                end
            end
            prev_latch = bus.latch;
            prev_digit = bus.digit;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.inc_hour = 1'b0;
        bus.inc_min  = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse(input bit h, input bit m);
        @(negedge clk);
        bus.inc_hour = h;
        bus.inc_min  = m;
        @(negedge clk);
        bus.inc_hour = 1'b0;
        bus.inc_min  = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (frames.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (frames.size() < target) begin
            n_tests++; n_fail++;
            $display("FAIL %s timeout: frames %0d, required %0d", name, frames.size(), target);
        end
    endtask

    task automatic wait_settled(input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clk);
            quiet = bus.busy ? 0 : quiet + 1;
            n++;
        end
        if (quiet < 3) begin
            n_tests++; n_fail++;
            $display("FAIL settle timeout: busy still active after %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        int f0;
        rst = 1'b1;
        bus.inc_hour = 1'b0;
        bus.inc_min  = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (bus.digit !== 5'h0) begin n_fail++; $display("FAIL reset_digit: got %h, want 00", bus.digit); end
        n_tests++; if (bus.latch !== 1'b0) begin n_fail++; $display("FAIL reset_latch: got %b, want 0", bus.latch); end
        n_tests++; if (bus.busy  !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, want 0", bus.busy); end
        n_tests++; if (bus.tick  !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b, want 0", bus.tick); end
        f0 = frames.size();
        #1 rst = 1'b0;
        wait_frames(f0 + 1, 30, "reset_frame");
        n_tests++;
        if (done_cyc > 19) begin n_fail++; $display("FAIL reset_frame_time: done at cycle %0d, want <= 19", done_cyc); end
        n_tests++;
        if (last_frame !== exp_frame(0, 0, 0)) begin
            n_fail++; $display("FAIL reset_frame: got %h, want %h", last_frame, exp_frame(0, 0, 0));
        end
        @(negedge clk);
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_fall: got %b, want 0", bus.busy); end
    endtask

    task automatic test_sixty_ticks();
        do_reset();
        repeat (60 * HZ + 25) @(negedge clk);
        n_tests++;
        if (tick_count != 60) begin n_fail++; $display("FAIL tick_count: got %0d, want 60", tick_count); end
        n_tests++;
        if (last_frame !== exp_frame(0, 1, 0)) begin
            n_fail++; $display("FAIL sixty_ticks: got %h, want %h", last_frame, exp_frame(0, 1, 0));
        end
    endtask

    task automatic test_rollover();
        int n;
        do_reset();
        // Random spacing between set pulses; ticks may collide and get deferred
        for (int i = 0; i < 59; i++) begin
            pulse(i < 23, 1'b1);
            repeat ($urandom_range(3)) @(negedge clk);
        end
        n = 0;
        while (!(m_h == 23 && m_m == 59 && m_s == 59) && n < 5000) begin @(negedge clk); n++; end
        wait_settled(40);
        n_tests++;
        if (last_frame !== exp_frame(m_h, m_m, m_s) || m_s != 59) begin
            n_fail++; $display("FAIL preload: got %h, want %h", last_frame, exp_frame(23, 59, 59));
        end
        n = 0;
        while (m_s == 59 && n < 200) begin @(negedge clk); n++; end
        wait_settled(40);
        n_tests++;
        if (last_frame !== exp_frame(0, 0, 0)) begin
            n_fail++; $display("FAIL day_wrap: got %h, want %h", last_frame, exp_frame(0, 0, 0));
        end
    endtask

    task automatic test_collision();
        int n, f0;
        do_reset();
        n = 0;
        while (!(m_s == 5 && m_pc == HZ - 1) && n < 8 * HZ) begin @(negedge clk); n++; end
        f0 = frames.size();
        bus.inc_min = 1'b1;
        @(negedge clk);
        bus.inc_min = 1'b0;
        wait_frames(f0 + 2, 60, "collision");
        if (frames.size() >= f0 + 2) begin
            n_tests++;
            if (frames[f0] !== exp_frame(0, 1, 5)) begin
                n_fail++; $display("FAIL collision_first: got %h, want %h", frames[f0], exp_frame(0, 1, 5));
            end
            n_tests++;
            if (frames[f0+1] !== exp_frame(0, 1, 6)) begin
                n_fail++; $display("FAIL collision_second: got %h, want %h", frames[f0+1], exp_frame(0, 1, 6));
            end
            n_tests++;
            if (fs_last - fs_prev != 19) begin
                n_fail++; $display("FAIL back_to_back_gap: got %0d cycles, want 19", fs_last - fs_prev);
            end
        end
    endtask

    task automatic test_mid_frame();
        int n, f0;
        do_reset();
        wait_settled(40);
        f0 = frames.size();
        pulse(1'b0, 1'b1);
        n = 0;
        while (nfall < 8 && n < 40) begin @(negedge clk); n++; end
        pulse(1'b1, 1'b0);
        wait_frames(f0 + 2, 60, "mid_frame");
        if (frames.size() >= f0 + 2) begin
            n_tests++;
            if (frames[f0] !== exp_frame(0, 1, 0)) begin
                n_fail++; $display("FAIL mid_frame_old: got %h, want %h", frames[f0], exp_frame(0, 1, 0));
            end
            n_tests++;
            if (frames[f0+1] !== exp_frame(1, 1, 0)) begin
                n_fail++; $display("FAIL mid_frame_new: got %h, want %h", frames[f0+1], exp_frame(1, 1, 0));
            end
        end
        n_tests++;
        if (stab_err != 0) begin n_fail++; $display("FAIL digit_stability: got %0d glitches, want 0", stab_err); end
    endtask

    task automatic test_reset_mid();
        int n, f0;
        do_reset();
        n = 0;
        repeat ($urandom_range(6)) @(negedge clk);
        while (!bus.latch && n < 30) begin @(negedge clk); n++; end
        #1 rst = 1'b1;
        #1;
        n_tests++; if (bus.latch !== 1'b0) begin n_fail++; $display("FAIL abort_latch: got %b, want 0", bus.latch); end
        n_tests++; if (bus.busy  !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, want 0", bus.busy); end
        n_tests++; if (bus.digit !== 5'h0) begin n_fail++; $display("FAIL abort_digit: got %h, want 00", bus.digit); end
        @(negedge clk);
        f0 = frames.size();
        @(negedge clk) #1 rst = 1'b0;
        wait_frames(f0 + 1, 30, "abort_refresh");
        n_tests++;
        if (last_frame !== exp_frame(0, 0, 0)) begin
            n_fail++; $display("FAIL abort_refresh: got %h, want %h", last_frame, exp_frame(0, 0, 0));
        end
    endtask

    task automatic test_integrity();
        n_tests++;
        if (tick_err != 0) begin n_fail++; $display("FAIL tick_timing: got %0d bad cycles, want 0", tick_err); end
        n_tests++;
        if (stab_err != 0) begin n_fail++; $display("FAIL digit_stability_all: got %0d glitches, want 0", stab_err); end
    endtask

    initial begin
        bus.inc_hour = 1'b0;
        bus.inc_min  = 1'b0;
        test_reset();
        test_sixty_ticks();
        test_rollover();
        test_collision();
        test_mid_frame();
        test_reset_mid();
        test_integrity();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
